cpu_trace_monitor: RTL and testbench

Parametrised instruction-trace monitor that sits beside `cpu2` and taps its retire stream: pc, instruction word, active register-file write address and active data-memory address. Once armed, it records one entry per retired instruction into a ring buffer and counts instructions. It stops on an instruction-count limit or a halt opcode, stalls the core, then drains the captured window oldest-first over a valid/ready port. It replaces ad-hoc per-cycle printing with a synthesizable, depth-configurable trace that both the bench and hardware debug can read.

---
 rtl/cpu_trace_monitor.sv | 131 +++++++++++++
 tb/tb_cpu_trace_monitor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_monitor.sv
// Instruction-trace monitor for the cpu2 retire stream: ring-buffer capture after arm,
// stop on count limit or halt opcode, then stall the core and drain oldest-first.
module cpu_trace_monitor #(
    parameter int          DEPTH      = 8,
    parameter int          PC_W       = 32,
    parameter int          ADDR_W     = 32,
    parameter int          CNT_W      = 17,
    parameter int          LIMIT      = 16,
    parameter int          HALT_EN    = 1,
    parameter logic [31:0] HALT_INSTR = 32'h0000000c
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ret,
    input  logic [PC_W-1:0]             pc,
    input  logic [31:0]                 instr,
    input  logic [4:0]                  reg_waddr,
    input  logic [ADDR_W-1:0]           dm_addr,
    input  logic                        arm,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic [PC_W+32+5+ADDR_W-1:0] rd_data,
    output logic [CNT_W-1:0]            count,
    output logic                        cpu_stall,
    output logic                        halted,
    output logic [1:0]                  state
);
    localparam int DW     = PC_W + 32 + 5 + ADDR_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [PTR_W-1:0]    r_wr_ptr, w_wr_ptr_nxt, r_rd_ptr, w_rd_ptr_nxt;
    logic [FILL_W-1:0]   r_fill, w_fill_nxt, r_rem, w_rem_nxt;
    logic [CNT_W-1:0]    r_count, w_count_nxt;
    logic [DW-1:0]       r_mem [DEPTH];

    logic                w_cap, w_stop, w_hs;
    logic [PTR_W-1:0]    w_wr_inc;
    logic [FILL_W-1:0]   w_fill_inc;
    logic [CNT_W-1:0]    w_cnt_inc;

    assign w_cap      = (r_state == S_CAPTURE) && ret;
    assign w_wr_inc   = r_wr_ptr + PTR_W'(1);
    assign w_fill_inc = (r_fill == FILL_W'(DEPTH)) ? r_fill : r_fill + FILL_W'(1);
    assign w_cnt_inc  = (&r_count) ? r_count : r_count + CNT_W'(1);
    // Stop test uses the post-increment count so the triggering instruction is included.
    assign w_stop     = ((LIMIT != 0) && (w_cnt_inc == CNT_W'(LIMIT))) ||
                        ((HALT_EN != 0) && (instr == HALT_INSTR));
    assign w_hs       = rd_valid && rd_ready;

    assign rd_valid  = (r_state == S_DRAIN) && (r_rem != '0);
    assign rd_data   = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign cpu_stall = (r_state == S_DRAIN) || (r_state == S_DONE);
    assign halted    = (r_state == S_DONE);
    assign state     = r_state;

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_fill_nxt   = r_fill;
        w_rem_nxt    = r_rem;
        w_count_nxt  = r_count;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    w_state_nxt  = S_CAPTURE;
                    w_wr_ptr_nxt = '0;
                    w_rd_ptr_nxt = '0;
                    w_fill_nxt   = '0;
                    w_rem_nxt    = '0;
                    w_count_nxt  = '0;
                end
            end
            S_CAPTURE: begin
                if (ret) begin
                    w_wr_ptr_nxt = w_wr_inc;
                    w_fill_nxt   = w_fill_inc;
                    w_count_nxt  = w_cnt_inc;
                    if (w_stop) begin
                        // Once wrapped, the oldest entry sits at the next write slot.
                        w_state_nxt  = S_DRAIN;
                        w_rd_ptr_nxt = (w_fill_inc < FILL_W'(DEPTH)) ? '0 : w_wr_inc;
                        w_rem_nxt    = w_fill_inc;
                    end
                end
            end
            S_DRAIN: begin
                if (r_rem == '0) begin
                    w_state_nxt = S_DONE;
                end else if (w_hs) begin
                    w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
                    w_rem_nxt    = r_rem - FILL_W'(1);
                    if (r_rem == FILL_W'(1)) w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_rem    <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_fill   <= w_fill_nxt;
            r_rem    <= w_rem_nxt;
            r_count  <= w_count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_cap) r_mem[r_wr_ptr] <= {pc, instr, reg_waddr, dm_addr};
    end
endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench: limit stop, halt opcode, backpressure, arm collisions, reset mid-drain
// (LIMIT=6 instance) and buffer wrap (LIMIT=16 instance).
module tb_cpu_trace_monitor;
    localparam int DW = 32 + 32 + 5 + 32;

    logic          clk = 1'b0;
    logic          reset, ret, arm_a, arm_b, rd_ready;
    logic [31:0]   pc, instr, dm_addr;
    logic [4:0]    reg_waddr;

    logic          rd_valid_a, cpu_stall_a, halted_a;
    logic [DW-1:0] rd_data_a;
    logic [16:0]   count_a;
    logic [1:0]    state_a;
    logic          rd_valid_b, cpu_stall_b, halted_b;
    logic [DW-1:0] rd_data_b;
    logic [16:0]   count_b;
    logic [1:0]    state_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_trace_monitor #(.DEPTH(8), .LIMIT(6)) u_a (
        .clk(clk), .reset(reset), .ret(ret), .pc(pc), .instr(instr),
        .reg_waddr(reg_waddr), .dm_addr(dm_addr), .arm(arm_a),
        .rd_valid(rd_valid_a), .rd_ready(rd_ready), .rd_data(rd_data_a),
        .count(count_a), .cpu_stall(cpu_stall_a), .halted(halted_a), .state(state_a)
    );

    cpu_trace_monitor #(.DEPTH(8), .LIMIT(16)) u_b (
        .clk(clk), .reset(reset), .ret(ret), .pc(pc), .instr(instr),
        .reg_waddr(reg_waddr), .dm_addr(dm_addr), .arm(arm_b),
        .rd_valid(rd_valid_b), .rd_ready(rd_ready), .rd_data(rd_data_b),
        .count(count_b), .cpu_stall(cpu_stall_b), .halted(halted_b), .state(state_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] entry(input int i, input logic [31:0] ins);
        logic [31:0] p;
        logic [31:0] d;
        logic [4:0]  r;
        p = 32'(4 * i);
        d = 32'h1000 + 32'(i);
        r = 5'(i);
        return {p, ins, r, d};
    endfunction

    task automatic drive_ret(input int i, input logic [31:0] ins);
        ret       = 1'b1;
        pc        = 32'(4 * i);
        instr     = ins;
        reg_waddr = 5'(i);
        dm_addr   = 32'h1000 + 32'(i);
    endtask

    initial begin
        reset = 1'b1; ret = 1'b0; arm_a = 1'b0; arm_b = 1'b0; rd_ready = 1'b0;
        pc = '0; instr = '0; reg_waddr = '0; dm_addr = '0;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_state", 128'(state_a), 128'd0);
        chk("rst_count", 128'(count_a), 128'd0);
        chk("rst_valid", 128'(rd_valid_a), 128'd0);
        chk("rst_stall", 128'(cpu_stall_a), 128'd0);
        chk("rst_halted", 128'(halted_a), 128'd0);

        // Limit stop with arm/ret collision, mid-capture arm and backpressured drain
        arm_a = 1'b1;
        drive_ret(25, 32'h100);
        step();
        arm_a = 1'b0; ret = 1'b0;
        chk("coll_state", 128'(state_a), 128'd1);
        chk("coll_count", 128'(count_a), 128'd0);
        for (int i = 0; i < 6; i++) begin
            drive_ret(i, 32'h100 + 32'(i));
            arm_a = (i == 2);
            step();
            if (i == 2) chk("arm_mid_count", 128'(count_a), 128'd3);
            if (i == 4) chk("pre_stop_stall", 128'(cpu_stall_a), 128'd0);
        end
        ret = 1'b0; arm_a = 1'b0;
        chk("lim_stall", 128'(cpu_stall_a), 128'd1);
        chk("lim_state", 128'(state_a), 128'd2);
        chk("lim_count", 128'(count_a), 128'd6);
        for (int k = 0; k < 6; k++) begin
            chk("lim_valid", 128'(rd_valid_a), 128'd1);
            chk("lim_data", 128'(rd_data_a), 128'(entry(k, 32'h100 + 32'(k))));
            if (k % 2 == 1) begin
                rd_ready = 1'b0;
                for (int h = 0; h < 2; h++) begin
                    step();
                    chk("bp_hold", 128'(rd_data_a), 128'(entry(k, 32'h100 + 32'(k))));
                    chk("bp_valid", 128'(rd_valid_a), 128'd1);
                end
            end
            rd_ready = 1'b1;
            step();
            rd_ready = 1'b0;
        end
        chk("lim_halted", 128'(halted_a), 128'd1);
        chk("lim_done_valid", 128'(rd_valid_a), 128'd0);
        chk("lim_done_state", 128'(state_a), 128'd3);
        chk("lim_done_count", 128'(count_a), 128'd6);

        // Halt opcode on the 4th instruction
        arm_a = 1'b1;
        step();
        arm_a = 1'b0;
        chk("halt_rearm_state", 128'(state_a), 128'd1);
        chk("halt_rearm_halted", 128'(halted_a), 128'd0);
        chk("halt_rearm_count", 128'(count_a), 128'd0);
        for (int i = 0; i < 4; i++) begin
            drive_ret(i, (i == 3) ? 32'h0000000c : 32'h200 + 32'(i));
            step();
        end
        ret = 1'b0;
        chk("halt_state", 128'(state_a), 128'd2);
        chk("halt_count", 128'(count_a), 128'd4);
        rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("halt_valid", 128'(rd_valid_a), 128'd1);
            chk("halt_data", 128'(rd_data_a),
                128'(entry(k, (k == 3) ? 32'h0000000c : 32'h200 + 32'(k))));
            step();
        end
        rd_ready = 1'b0;
        chk("halt_halted", 128'(halted_a), 128'd1);

        // Wrap: 16 captures into 8 entries, drain pc 32..60
        arm_b = 1'b1;
        step();
        arm_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_ret(i, 32'h300 + 32'(i));
            step();
        end
        ret = 1'b0;
        chk("wrap_state", 128'(state_b), 128'd2);
        chk("wrap_count", 128'(count_b), 128'd16);
        chk("wrap_a_idle", 128'(state_a), 128'd3);
        rd_ready = 1'b1;
        for (int k = 8; k < 16; k++) begin
            chk("wrap_valid", 128'(rd_valid_b), 128'd1);
            chk("wrap_data", 128'(rd_data_b), 128'(entry(k, 32'h300 + 32'(k))));
            step();
        end
        rd_ready = 1'b0;
        chk("wrap_halted", 128'(halted_b), 128'd1);
        chk("wrap_done_valid", 128'(rd_valid_b), 128'd0);

        // Reset after 2 of 6 entries drained, then re-arm
        arm_a = 1'b1;
        step();
        arm_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_ret(i, 32'h400 + 32'(i));
            step();
        end
        ret = 1'b0;
        rd_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("rstd_data", 128'(rd_data_a), 128'(entry(k, 32'h400 + 32'(k))));
            step();
        end
        rd_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstd_state", 128'(state_a), 128'd0);
        chk("rstd_valid", 128'(rd_valid_a), 128'd0);
        chk("rstd_stall", 128'(cpu_stall_a), 128'd0);
        chk("rstd_count", 128'(count_a), 128'd0);
        arm_a = 1'b1;
        step();
        arm_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_ret(i + 1, 32'h500 + 32'(i));
            step();
        end
        ret = 1'b0;
        chk("rearm_count", 128'(count_a), 128'd6);
        chk("rearm_stall", 128'(cpu_stall_a), 128'd1);
        chk("rearm_data", 128'(rd_data_a), 128'(entry(1, 32'h500)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
